// File: rtl/lc3_execute.sv
// LC-3 execute stage: ALU, branch/jump target adder, NZP mask and stage registers; 1-cycle latency.
// Outputs hold while enable_execute=0. Operand forwarding compiled in only with `define LC3_EXEC_BYPASS_EN.
module lc3_execute (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable_execute,
    input  logic [15:0] IR,
    input  logic [15:0] npc_in,
    input  logic [5:0]  E_Control,
    input  logic [1:0]  W_Control_in,
    input  logic        Mem_Control_in,
    input  logic [15:0] VSR1,
    input  logic [15:0] VSR2,
    input  logic        bypass_alu_1,
    input  logic        bypass_alu_2,
    input  logic        bypass_mem_1,
    input  logic        bypass_mem_2,
    input  logic [15:0] Mem_Bypass_Val,
    output logic [15:0] aluout,
    output logic [15:0] pcout,
    output logic [1:0]  W_Control_out,
    output logic        Mem_Control_out,
    output logic [15:0] M_Data,
    output logic [2:0]  dr,
    output logic [2:0]  NZP,
    output logic [15:0] IR_Exec,
    output logic [2:0]  sr1,
    output logic [2:0]  sr2
);

    logic [1:0]  alu_control;
    logic [1:0]  pcselect1;
    logic        pcselect2;
    logic        op2select;
    logic [3:0]  opcode;

    logic [15:0] vsr1_fwd;
    logic [15:0] vsr2_fwd;
    logic [15:0] op1;
    logic [15:0] op2;
    logic [15:0] pc_base;
    logic [15:0] pc_offset;

    logic [15:0] aluout_d,   aluout_q;
    logic [15:0] pcout_d,    pcout_q;
    logic [1:0]  w_ctrl_d,   w_ctrl_q;
    logic        mem_ctrl_d, mem_ctrl_q;
    logic [15:0] m_data_d,   m_data_q;
    logic [2:0]  dr_d,       dr_q;
    logic [2:0]  nzp_d,      nzp_q;
    logic [15:0] ir_exec_d,  ir_exec_q;

    assign alu_control = E_Control[5:4];
    assign pcselect1   = E_Control[3:2];
    assign pcselect2   = E_Control[1];
    assign op2select   = E_Control[0];
    assign opcode      = IR[15:12];

    // Source register indices go to the regfile in the same cycle, so they bypass the stage registers.
    assign sr1 = IR[8:6];
    always_comb begin
        sr2 = IR[2:0];
        if (opcode == 4'b0011 || opcode == 4'b0111 || opcode == 4'b1011)
            sr2 = IR[11:9];
    end

`ifdef LC3_EXEC_BYPASS_EN
    always_comb begin
        vsr1_fwd = VSR1;
        if (bypass_alu_1)      vsr1_fwd = aluout_q;
        else if (bypass_mem_1) vsr1_fwd = Mem_Bypass_Val;
        vsr2_fwd = VSR2;
        if (bypass_alu_2)      vsr2_fwd = aluout_q;
        else if (bypass_mem_2) vsr2_fwd = Mem_Bypass_Val;
    end
`else
    logic unused_bypass;
    assign unused_bypass = ^{bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2, Mem_Bypass_Val};
    assign vsr1_fwd = VSR1;
    assign vsr2_fwd = VSR2;
`endif

    assign op1 = vsr1_fwd;
    assign op2 = op2select ? vsr2_fwd : {{11{IR[4]}}, IR[4:0]};

    always_comb begin
        case (alu_control)
            2'b00:   aluout_d = op1 + op2;
            2'b01:   aluout_d = op1 & op2;
            2'b10:   aluout_d = ~op1;
            default: aluout_d = 16'h0000;
        endcase
    end

    always_comb begin
        case (pcselect1)
            2'b00:   pc_offset = {{5{IR[10]}}, IR[10:0]};
            2'b01:   pc_offset = {{7{IR[8]}},  IR[8:0]};
            2'b10:   pc_offset = {{10{IR[5]}}, IR[5:0]};
            default: pc_offset = 16'h0000;
        endcase
    end

    assign pc_base = pcselect2 ? npc_in : op1;
    assign pcout_d = pc_base + pc_offset;

    always_comb begin
        nzp_d = 3'b000;
        if (opcode == 4'b0000)      nzp_d = IR[11:9];
        else if (opcode == 4'b1100) nzp_d = 3'b111;
    end

    assign w_ctrl_d   = W_Control_in;
    assign mem_ctrl_d = Mem_Control_in;
    assign m_data_d   = vsr2_fwd;
    assign dr_d       = IR[11:9];
    assign ir_exec_d  = IR;

    always_ff @(posedge clock) begin
        if (!reset) begin
            aluout_q   <= 16'h0000;
            pcout_q    <= 16'h0000;
            w_ctrl_q   <= 2'b00;
            mem_ctrl_q <= 1'b0;
            m_data_q   <= 16'h0000;
            dr_q       <= 3'b000;
            nzp_q      <= 3'b000;
            ir_exec_q  <= 16'h0000;
        end else if (enable_execute) begin
            aluout_q   <= aluout_d;
            pcout_q    <= pcout_d;
            w_ctrl_q   <= w_ctrl_d;
            mem_ctrl_q <= mem_ctrl_d;
            m_data_q   <= m_data_d;
            dr_q       <= dr_d;
            nzp_q      <= nzp_d;
            ir_exec_q  <= ir_exec_d;
        end
    end

    assign aluout          = aluout_q;
    assign pcout           = pcout_q;
    assign W_Control_out   = w_ctrl_q;
    assign Mem_Control_out = mem_ctrl_q;
    assign M_Data          = m_data_q;
    assign dr              = dr_q;
    assign NZP             = nzp_q;
    assign IR_Exec         = ir_exec_q;

endmodule
